// File: rtl/usb_line_pkg.sv
// -----------------------------------------------------------------------------
// usb_line_pkg
//   Shared types and constants for the usb_line_echo line-echo block.
//
//   Contents:
//     state_t     - line echo state machine encoding
//     CHAR_CR     - carriage return (0x0D)
//     CHAR_LF     - line feed (0x0A)
//     CHAR_BS     - backspace (0x08)
//     CASE_OFFSET - distance between ASCII lower and upper case (0x20)
//     to_upper()  - lower-case to upper-case helper, only present when
//                   USB_LINE_ECHO_UPCASE_EN is defined
// -----------------------------------------------------------------------------
package usb_line_pkg;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,  // accepting bytes into the line buffer
    FETCH   = 3'd1,  // one-cycle read of buffer index 0
    EMIT    = 3'd2,  // streaming the stored line out
    EOL_CR  = 3'd3,  // presenting the CR of the line end
    EOL_LF  = 3'd4   // presenting the LF of the line end
  } state_t;

  localparam logic [7:0] CHAR_CR     = 8'h0D;
  localparam logic [7:0] CHAR_LF     = 8'h0A;
  localparam logic [7:0] CHAR_BS     = 8'h08;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

`ifdef USB_LINE_ECHO_UPCASE_EN
  localparam logic [7:0] CHAR_LOWER_A = 8'h61;
  localparam logic [7:0] CHAR_LOWER_Z = 8'h7A;

  // Maps 'a'..'z' onto 'A'..'Z'; every other byte passes through.
  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if ((b >= CHAR_LOWER_A) && (b <= CHAR_LOWER_Z)) begin
      return b - CASE_OFFSET;
    end
    return b;
  endfunction
`endif

endpackage : usb_line_pkg

// File: rtl/line_buf_mem.sv
// -----------------------------------------------------------------------------
// line_buf_mem
//   DEPTH x 8 line buffer: one write port, one synchronous read port with a
//   single cycle of read latency. Shaped so it maps onto an iCE40 block RAM.
//
//   Parameters:
//     DEPTH   - number of bytes (power of two)
//     AW      - address width, derived from DEPTH
//   Ports:
//     clk_48mhz - clock, all activity on the rising edge
//     wr_en     - write wr_data at wr_addr on this edge
//     wr_addr   - write address
//     wr_data   - write byte
//     rd_en     - load rd_data from rd_addr on this edge
//     rd_addr   - read address
//     rd_data   - registered read byte, holds while rd_en is low
// -----------------------------------------------------------------------------
module line_buf_mem #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_48mhz,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset; a reset would stop
  // the tools from mapping them onto block RAM. Nothing reads stale contents
  // because a line is always written before it is fetched.
  always_ff @(posedge clk_48mhz) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule : line_buf_mem

// File: rtl/usb_line_echo.sv
// -----------------------------------------------------------------------------
// usb_line_echo
//   Collects bytes from the USB UART receive stream into a line buffer with
//   backspace editing. On CR or LF (or when the buffer fills) it echoes the
//   line back followed by CR LF. Input is blocked while a line is echoed.
//
//   Configuration macro:
//     USB_LINE_ECHO_UPCASE_EN - when defined, 'a'..'z' are upper-cased on
//                               their way out (stored bytes and the CR LF
//                               line end are unaffected).
//
//   Parameters:
//     DEPTH     - line buffer capacity in bytes (power of two, 4..256)
//   Ports:
//     clk_48mhz - system clock, rising edge
//     reset     - synchronous, active-high reset
//     in_data   - received byte (from usb_uart uart_out_data)
//     in_valid  - in_data valid
//     in_ready  - byte accepted when in_valid && in_ready on an edge
//     out_data  - byte to transmit (to usb_uart uart_in_data)
//     out_valid - out_data valid
//     out_ready - byte consumed when out_valid && out_ready on an edge
//     busy      - high while not collecting (echo in progress)
// -----------------------------------------------------------------------------
module usb_line_echo #(
  parameter int DEPTH = 64
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  import usb_line_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // count needs one extra bit so a completely full buffer is representable.
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [AW-1:0] IDX_ONE    = AW'(1);

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic [AW-1:0] rd_idx, rd_idx_next;

  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [7:0]    emit_byte;

  // ---------------------------------------------------------------------------
  // Line buffer. Writes happen only in COLLECT and reads only in FETCH/EMIT,
  // so the two ports are never active in the same cycle.
  // ---------------------------------------------------------------------------
  line_buf_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_line_buf_mem (
    .clk_48mhz (clk_48mhz),
    .wr_en     (wr_en),
    .wr_addr   (count[AW-1:0]),
    .wr_data   (in_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

`ifdef USB_LINE_ECHO_UPCASE_EN
  assign emit_byte = to_upper(rd_data);
`else
  assign emit_byte = rd_data;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state  <= COLLECT;
      count  <= '0;
      rd_idx <= '0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      rd_idx <= rd_idx_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    count_next  = count;
    rd_idx_next = rd_idx;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = rd_idx;

    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if ((in_data == CHAR_CR) || (in_data == CHAR_LF)) begin
            // An empty line skips straight to the line end.
            state_next = (count != '0) ? FETCH : EOL_CR;
          end else if (in_data == CHAR_BS) begin
            if (count != '0) begin
              count_next = count - COUNT_ONE;
            end
          end else begin
            wr_en      = 1'b1;
            count_next = count + COUNT_ONE;
            // Storing the last free slot forces a line break.
            if (count == (COUNT_FULL - COUNT_ONE)) begin
              state_next = FETCH;
            end
          end
        end
      end

      FETCH: begin
        // Prime the read register with index 0 so EMIT starts with data.
        rd_en      = 1'b1;
        rd_addr    = '0;
        state_next = EMIT;
      end

      EMIT: begin
        out_valid = 1'b1;
        out_data  = emit_byte;
        // Re-reading the current index while stalled keeps rd_data steady;
        // on a handshake the next index is read so it appears on the
        // following edge without a bubble.
        rd_en = 1'b1;
        if (out_ready) begin
          if ({1'b0, rd_idx} == (count - COUNT_ONE)) begin
            // Last byte: hold rd_idx rather than step past the line.
            state_next = EOL_CR;
          end else begin
            rd_idx_next = rd_idx + IDX_ONE;
            rd_addr     = rd_idx + IDX_ONE;
          end
        end
      end

      EOL_CR: begin
        out_valid = 1'b1;
        out_data  = CHAR_CR;
        if (out_ready) begin
          state_next = EOL_LF;
        end
      end

      EOL_LF: begin
        out_valid = 1'b1;
        out_data  = CHAR_LF;
        if (out_ready) begin
          count_next  = '0;
          rd_idx_next = '0;
          state_next  = COLLECT;
        end
      end

      default: begin
        state_next = COLLECT;
      end
    endcase
  end

  assign busy = (state != COLLECT);

endmodule : usb_line_echo

// File: tb/tb_usb_line_echo.sv
// -----------------------------------------------------------------------------
// tb_usb_line_echo
//   Self-checking bench for usb_line_echo (DEPTH = 64). A queue-based model
//   turns accepted input bytes into the expected output byte stream, and the
//   expected in_ready/busy/out_valid levels follow from whether that stream
//   still has bytes pending. Define USB_LINE_ECHO_UPCASE_EN for both the RTL
//   and this bench to exercise the upper-case variant.
// -----------------------------------------------------------------------------
module tb_usb_line_echo;

  localparam int DEPTH = 64;

  logic       clk_48mhz = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] in_data   = 8'h00;
  logic       in_valid  = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;

  always #5 clk_48mhz = ~clk_48mhz;

  usb_line_echo #(.DEPTH(DEPTH)) dut (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  int checks   = 0;
  int failures = 0;

  byte unsigned pending[$];  // bytes still to be offered on the input
  byte unsigned line_q[$];   // model of the line being collected
  byte unsigned exp_q[$];    // expected output stream not yet consumed

  bit         fetch_next;    // next cycle is the read-latency gap of a line
  int         ready_mode;    // 0: always ready, 1: 1,0,0 pattern, 2: random
  int         cyc;
  int         out_count;
  bit         prev_stall;
  logic [7:0] prev_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic byte unsigned emit_form(input byte unsigned b);
`ifdef USB_LINE_ECHO_UPCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
    return b;
  endfunction

  task automatic flush_line();
    // A non-empty line needs one cycle for the buffer read before output.
    if (line_q.size() > 0) fetch_next = 1'b1;
    foreach (line_q[i]) exp_q.push_back(emit_form(line_q[i]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    line_q.delete();
  endtask

  task automatic model_accept(input byte unsigned b);
    if (b == 8'h0D || b == 8'h0A) begin
      flush_line();
    end else if (b == 8'h08) begin
      if (line_q.size() > 0) void'(line_q.pop_back());
    end else begin
      line_q.push_back(b);
      if (line_q.size() == DEPTH) flush_line();
    end
  endtask

  // ---------------------------------------------------------------------------
  // One clock cycle: called at a falling edge, returns at the next one.
  // ---------------------------------------------------------------------------
  task automatic step();
    bit exp_busy;
    bit exp_valid;
    exp_busy  = (exp_q.size() > 0);
    exp_valid = exp_busy && !fetch_next;
    check("in_ready", in_ready, !exp_busy);
    check("busy", busy, exp_busy);
    check("out_valid", out_valid, exp_valid);
    if (prev_stall) check("stall_hold", out_data, prev_data);
    fetch_next = 1'b0;

    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((cyc % 3) == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    in_valid = (pending.size() > 0);
    in_data  = in_valid ? pending[0] : 8'h00;

    if (in_valid && !exp_busy) model_accept(pending.pop_front());
    if (exp_valid && out_ready) begin
      check("out_data", out_data, exp_q.pop_front());
      out_count++;
    end
    prev_stall = exp_valid && !out_ready;
    prev_data  = out_data;
    cyc++;
    @(posedge clk_48mhz);
    @(negedge clk_48mhz);
  endtask

  task automatic send_str(input string s);
    foreach (s[i]) pending.push_back(s[i]);
  endtask

  task automatic run_idle(input int max_cycles);
    int n;
    n = 0;
    while ((pending.size() > 0 || exp_q.size() > 0) && n < max_cycles) begin
      step();
      n++;
    end
    check("drain", pending.size() + exp_q.size(), 0);
    step();
  endtask

  // Called at a falling edge: one reset edge, then the post-reset state.
  task automatic pulse_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    reset = 1'b0;
    pending.delete();
    line_q.delete();
    exp_q.delete();
    fetch_next = 1'b0;
    prev_stall = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, 8'h00);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int base;
    int r;
    byte unsigned b;

    fetch_next = 1'b0;
    ready_mode = 0;
    cyc        = 0;
    out_count  = 0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;

    repeat (2) @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    pulse_reset();

    // Basic line, always ready: first byte two edges after CR, no bubbles.
    send_str("abc\r");
    run_idle(100);

    // Backspace editing and LF terminator.
    pending.push_back(8'h61); pending.push_back(8'h62);
    pending.push_back(8'h08); pending.push_back(8'h63);
    pending.push_back(8'h0A);
    run_idle(100);

    // Backspace on an empty line is ignored; empty line emits CR LF.
    pending.push_back(8'h08); pending.push_back(8'h0D);
    run_idle(100);

    // CR followed by LF gives two line ends.
    pending.push_back(8'h0D); pending.push_back(8'h0A);
    run_idle(100);

    // Full buffer forces a line break; next byte waits for the LF handshake.
    for (int i = 0; i < DEPTH; i++) pending.push_back(8'(8'h30 + i));
    send_str("Z\r");
    run_idle(400);

    // Output back-pressure with a 1,0,0 ready pattern.
    ready_mode = 1;
    send_str("xy\r");
    run_idle(200);

    // Reset right after the first echoed byte discards the rest of the line.
    ready_mode = 0;
    send_str("hello\r");
    base = out_count;
    n    = 0;
    while (out_count == base && n < 200) begin
      step();
      n++;
    end
    check("first_byte_seen", out_count - base, 1);
    pulse_reset();
    send_str("A\r");
    run_idle(100);

    // Case conversion (only active with the upper-case build).
    send_str("aZ{\r");
    run_idle(100);

    // Randomised traffic with random output back-pressure.
    ready_mode = 2;
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 6)       b = 8'h0D;
      else if (r < 9)  b = 8'h0A;
      else if (r < 15) b = 8'h08;
      else             b = 8'($urandom_range(8'h20, 8'h7E));
      pending.push_back(b);
    end
    pending.push_back(8'h0D);
    run_idle(20000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_usb_line_echo
